// File: rtl/enc_pkg.sv
// Shared types and constants for the program-1 message-encryption engine.
package enc_pkg;

  // Controller states, in run order.
  typedef enum logic [2:0] {
    IDLE,
    LD_PRE,
    LD_TAP,
    LD_INIT,
    RUN,
    DONE
  } state_t;

  // Fixed memory map (byte addresses).
  localparam logic [7:0] MSG_BASE  = 8'd0;
  localparam logic [7:0] PRE_ADDR  = 8'd61;
  localparam logic [7:0] TAP_ADDR  = 8'd62;
  localparam logic [7:0] SEED_ADDR = 8'd63;
  localparam logic [7:0] OUT_BASE  = 8'd64;

  // Number of encrypted bytes produced per run.
  localparam int NUM_OUT = 64;

  // One LFSR step: shift the low six bits up, insert the tap parity at bit 0.
  // Bit 7 of the result is always 0; bit 7 of the seed only feeds the parity.
  function automatic logic [7:0] lfsr_next(input logic [7:0] cur, input logic [7:0] taps);
    return {1'b0, cur[5:0], ^(cur & taps)};
  endfunction

endpackage

// File: rtl/data_mem.sv
// 256x8 data memory: combinational read, synchronous single-port write.
module data_mem
  import enc_pkg::*;
(
  input  logic       clk,
  input  logic       we,
  input  logic [7:0] waddr,
  input  logic [7:0] wdata,
  input  logic [7:0] raddr,
  output logic [7:0] rdata
);

  logic [7:0] core [256];

  assign rdata = core[raddr];

  // Write port: one byte per cycle when enabled.
  // NOTE: the array has no reset on purpose -- its contents (the message and
  // any outputs already written) must survive a reset of the engine.
  always_ff @(posedge clk) begin
    if (we) core[waddr] <= wdata;
  end

endmodule

// File: rtl/top_level.sv
// Message-encryption engine: reads a biased message, preamble length, LFSR
// taps and seed from DM1, writes 64 encrypted bytes back and raises ack.
module top_level
  import enc_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic Start,
  output logic ack
);

  localparam logic [5:0] LAST_IDX = 6'(NUM_OUT - 1);

  state_t     state, state_nxt;
  logic [7:0] pre, taps, lfsr;
  logic [5:0] idx;

  logic       we;
  logic [7:0] raddr, rdata, waddr, wdata;
  logic [7:0] pos, src, ch;

  data_mem DM1 (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (raddr),
    .rdata (rdata)
  );

  // State register; reset returns to IDLE and aborts any run in progress.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  // NOTE: state_nxt gets a default before the case so no path infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!Start) state_nxt = LD_PRE;
      LD_PRE:  state_nxt = LD_TAP;
      LD_TAP:  state_nxt = LD_INIT;
      LD_INIT: state_nxt = RUN;
      RUN:     if (idx == LAST_IDX) state_nxt = DONE;
      DONE:    if (Start) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: read address selection, padding, encryption and write port.
  always_comb begin
    pos   = {2'b00, idx};
    src   = pos - pre;
    raddr = MSG_BASE + src;
    case (state)
      LD_PRE:  raddr = PRE_ADDR;
      LD_TAP:  raddr = TAP_ADDR;
      LD_INIT: raddr = SEED_ADDR;
      default: raddr = MSG_BASE + src;
    endcase
    // Preamble positions encrypt a zero character.
    ch    = (pos < pre) ? 8'h00 : rdata;
    wdata = {1'b0, ch[6:0] ^ lfsr[6:0]};
    waddr = OUT_BASE + pos;
    // Reset wins over a pending write in the same cycle.
    we    = (state == RUN) && !reset;
  end

  // Configuration latches, LFSR and output index.
  always_ff @(posedge clk) begin
    if (reset) begin
      pre  <= 8'h00;
      taps <= 8'h00;
      lfsr <= 8'h00;
      idx  <= 6'd0;
    end else begin
      case (state)
        LD_PRE:  pre  <= rdata;
        LD_TAP:  taps <= rdata;
        LD_INIT: begin
          lfsr <= rdata;
          idx  <= 6'd0;
        end
        RUN: begin
          lfsr <= lfsr_next(lfsr, taps);
          idx  <= idx + 6'd1;
        end
        default: ;
      endcase
    end
  end

  // ack decodes directly from the state flop, so it is glitch-free and 0 out of reset.
  assign ack = (state == DONE);

endmodule

// File: tb/tb_top_level.sv
// Self-checking bench for top_level: table vectors for the known-answer run,
// randomized runs against a behavioural model, and reset/handshake sequences.
module tb_top_level;
  import enc_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic Start;
  logic ack;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] snap    [256];
  logic [7:0] exp_out [64];

  typedef struct {
    logic [7:0] addr;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [11];

  top_level DUT (
    .clk   (clk),
    .reset (reset),
    .Start (Start),
    .ack   (ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic take_snapshot();
    for (int i = 0; i < 256; i++) snap[i] = DUT.DM1.core[i];
  endtask

  // Reference: pad the message with pre zeros, walk a 7-bit shift register
  // whose new low bit is the parity of (state & taps), and XOR.
  task automatic model_run();
    int pre_v, taps_v, l, c, par, masked;
    pre_v  = int'(snap[61]);
    taps_v = int'(snap[62]);
    l      = int'(snap[63]);
    for (int i = 0; i < 64; i++) begin
      c = (i < pre_v) ? 0 : int'(snap[i - pre_v]);
      exp_out[i] = 8'((c ^ l) % 128);
      masked = l & taps_v;
      par = 0;
      for (int b = 0; b < 8; b++) par = par + ((masked >> b) & 1);
      l = ((l * 2) % 128) - ((l * 2) % 2) + (par % 2);
    end
  endtask

  // Launch a run from IDLE and count edges after E0 until ack (bounded).
  task automatic run_engine(output int lat);
    Start = 1'b0;
    tick();
    lat = 0;
    while (ack !== 1'b1 && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  task automatic check_outputs(input string name);
    logic [7:0] any_b7;
    any_b7 = 8'h00;
    for (int i = 0; i < 64; i++) begin
      check($sformatf("%s out[%0d]", name, i), 32'(DUT.DM1.core[64 + i]), 32'(exp_out[i]));
      any_b7 = any_b7 | (DUT.DM1.core[64 + i] & 8'h80);
    end
    check({name, " bit7"}, 32'(any_b7), 32'h0);
    for (int i = 128; i < 256; i++)
      if (DUT.DM1.core[i] !== snap[i])
        check($sformatf("%s upper[%0d]", name, i), 32'(DUT.DM1.core[i]), 32'(snap[i]));
  endtask

  task automatic load_random(input int pre_v, input int taps_v);
    for (int i = 0; i < 61; i++) DUT.DM1.core[i] = 8'($urandom_range(0, 255));
    DUT.DM1.core[61] = 8'(pre_v);
    DUT.DM1.core[62] = 8'(taps_v);
    DUT.DM1.core[63] = 8'($urandom_range(0, 255));
  endtask

  initial begin
    int lat;
    logic ack_seen;
    int bad;

    vecs[0]  = '{8'd64, 8'h01};
    vecs[1]  = '{8'd65, 8'h02};
    vecs[2]  = '{8'd66, 8'h04};
    vecs[3]  = '{8'd67, 8'h08};
    vecs[4]  = '{8'd68, 8'h10};
    vecs[5]  = '{8'd69, 8'h20};
    vecs[6]  = '{8'd70, 8'h41};
    vecs[7]  = '{8'd71, 8'h03};
    vecs[8]  = '{8'd72, 8'h06};
    vecs[9]  = '{8'd73, 8'h0C};
    vecs[10] = '{8'd74, 8'h38};

    // Preload while reset is held high.
    reset = 1'b1;
    Start = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 256; i++) DUT.DM1.core[i] = 8'h00;
    for (int i = 0; i < 35; i++) DUT.DM1.core[i] = 8'h20;
    DUT.DM1.core[61] = 8'd10;
    DUT.DM1.core[62] = 8'h60;
    DUT.DM1.core[63] = 8'h01;
    for (int i = 64; i < 128; i++) DUT.DM1.core[i] = 8'hAA;
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("reset ack", 32'(ack), 32'h0);
    check("reset state", 32'(DUT.state), 32'(IDLE));
    check("preload msg", 32'(DUT.DM1.core[0]), 32'h20);
    check("preload pre", 32'(DUT.DM1.core[61]), 32'd10);
    check("preload seed", 32'(DUT.DM1.core[63]), 32'h01);

    // Start held high: nothing happens.
    take_snapshot();
    ack_seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      tick();
      ack_seen = ack_seen | ack;
    end
    check("idle ack", 32'(ack_seen), 32'h0);
    bad = 0;
    for (int i = 64; i < 128; i++) if (DUT.DM1.core[i] !== snap[i]) bad++;
    check("idle no writes", 32'(bad), 32'h0);

    // Known-answer run.
    model_run();
    run_engine(lat);
    check("kat latency", 32'(lat), 32'd67);
    for (int v = 0; v < 11; v++)
      check($sformatf("kat mem[%0d]", vecs[v].addr), 32'(DUT.DM1.core[vecs[v].addr]), 32'(vecs[v].exp));
    check_outputs("kat");

    // DONE holds while Start stays low, falls one edge after Start rises.
    tick();
    tick();
    check("done hold", 32'(ack), 32'h1);
    Start = 1'b1;
    tick();
    check("ack fall", 32'(ack), 32'h0);
    check("back idle", 32'(DUT.state), 32'(IDLE));

    // Second run with a new seed.
    DUT.DM1.core[63] = 8'($urandom_range(0, 255));
    take_snapshot();
    model_run();
    run_engine(lat);
    check("reseed latency", 32'(lat), 32'd67);
    check_outputs("reseed");
    Start = 1'b1;
    tick();

    // Randomized runs; the first uses the longest preamble and taps 0x48.
    for (int k = 0; k < 5; k++) begin
      if (k == 0) load_random(26, 8'h48);
      else        load_random(int'($urandom_range(10, 26)), int'($urandom_range(0, 255)));
      take_snapshot();
      model_run();
      run_engine(lat);
      check($sformatf("rand%0d latency", k), 32'(lat), 32'd67);
      check_outputs($sformatf("rand%0d", k));
      Start = 1'b1;
      tick();
    end

    // Reset during RUN at i = 20.
    load_random(int'($urandom_range(10, 26)), int'($urandom_range(0, 255)));
    for (int i = 64; i < 128; i++) DUT.DM1.core[i] = 8'h55;
    take_snapshot();
    model_run();
    Start = 1'b0;
    tick();
    repeat (3) tick();
    repeat (20) tick();
    reset = 1'b1;
    Start = 1'b1;
    tick();
    reset = 1'b0;
    check("abort ack", 32'(ack), 32'h0);
    check("abort state", 32'(DUT.state), 32'(IDLE));
    check("abort idx", 32'(DUT.idx), 32'h0);
    check("abort lfsr", 32'(DUT.lfsr), 32'h0);
    check("abort pre", 32'(DUT.pre), 32'h0);
    for (int i = 0; i < 84; i++) begin
      if (i < 64) begin
        if (DUT.DM1.core[i] !== snap[i])
          check($sformatf("abort low[%0d]", i), 32'(DUT.DM1.core[i]), 32'(snap[i]));
      end else begin
        check($sformatf("abort out[%0d]", i - 64), 32'(DUT.DM1.core[i]), 32'(exp_out[i - 64]));
      end
    end
    bad = 0;
    for (int i = 84; i < 128; i++) if (DUT.DM1.core[i] !== snap[i]) bad++;
    check("abort tail untouched", 32'(bad), 32'h0);
    tick();
    tick();
    check("abort stays idle", 32'(ack), 32'h0);

    // Engine recovers with a full run after the abort.
    take_snapshot();
    model_run();
    run_engine(lat);
    check("recover latency", 32'(lat), 32'd67);
    check_outputs("recover");
    Start = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/top_level.md
# top_level

Self-contained message-encryption engine with an embedded 256-byte data memory. On a start request it reads a biased ASCII message, a preamble length, a 7-bit LFSR tap pattern and a seed from fixed memory locations. It writes 64 encrypted bytes back into memory and raises a done flag. It is the top of the program-1 design; the bench preloads and inspects memory through the instance path `DM1.core`.

## Interface
Parameters:
- none; all sizes and addresses are fixed constants (see Structure).

Ports:
- clk  input  1  single system clock, rising-edge.
- reset  input  1  synchronous, active-high; one clock, reset is synchronous and active-high.
- Start  input  1  request; high holds the engine idle, a low level in IDLE launches a run.
- ack  output  1  done flag; high while in DONE.

## Operation
- Memory map (byte addresses):
  - 0..53: message, already biased by −0x20.
  - 61: preamble length `pre`.
  - 62: tap pattern `taps`.
  - 63: seed `init`.
  - 64..127: output.
  - Other locations are unused and untouched.
- Padded character c[i] for i = 0..63:
  - 0 if i < pre;
  - otherwise mem[i−pre].
  - Subtraction is 8-bit. `pre` is used unclamped (bench range 10..26).
- LFSR:
  - lfsr[0] = init.
  - lfsr[i+1] = {1'b0, lfsr[i][5:0], ^(lfsr[i] & taps)}, an 8-bit value with bit 7 always 0.
- Output: mem[64+i] = {1'b0, (c[i] ^ lfsr[i])[6:0]}.
- FSM states: IDLE, LD_PRE, LD_TAP, LD_INIT, RUN, DONE.
  - IDLE → LD_PRE when Start = 0.
  - LD_PRE latches `pre`, LD_TAP latches `taps`, LD_INIT latches `init` into the LFSR and clears i. Each moves to the next state unconditionally.
  - RUN: one output byte per cycle; advance the LFSR, i++. After writing i = 63, go to DONE.
  - DONE: ack = 1; stay until Start = 1, then go to IDLE.
- Reset:
  - State goes to IDLE, ack to 0, i/LFSR/latched registers to 0.
  - Memory contents are never modified by reset.
  - Reset mid-run aborts; already-written outputs remain.
- A new run requires Start high (return to IDLE) then low again.

## Timing
- Memory: combinational read, synchronous write, one write per cycle.
- Latency: edge E0 samples Start = 0 in IDLE. Edges E1..E3 perform the loads. Edges E4..E67 write outputs 0..63. ack goes high after E67 and stays until Start = 1 or reset.
- ack is registered (state-decoded from a flop); 0 out of reset.
- Start held high after reset: no memory writes, ack stays 0.
- reset and Start are sampled only at rising clk. reset has priority over everything.

## Structure
- Shared package `enc_pkg` holds:
  - the state enum;
  - address constants MSG_BASE = 0, PRE_ADDR = 61, TAP_ADDR = 62, SEED_ADDR = 63, OUT_BASE = 64;
  - NUM_OUT = 64.
- One sub-module `data_mem`, instanced as `DM1`:
  - 256×8 array named `core`;
  - async read, sync write, no reset.
- Controller, LFSR and datapath live in `top_level`.

## Test plan
- All '@' message (mem[0..34] = 0x20, rest 0), taps = 0x60, init = 0x01, pre = 10:
  - mem[64..73] = 01 02 04 08 10 20 41 03 06 0C;
  - mem[74] = 0x38 (0x20 ^ 0x18);
  - ack rises 67 cycles after Start sampled low.
- Start held high for 100 cycles after reset → ack = 0, mem[64..127] unchanged.
- pre = 26, taps = 0x48, random seed, 54-char message → all 64 bytes match the reference model; bit 7 always 0.
- Assert reset during RUN at i = 20 → ack = 0, state IDLE, mem[84..127] unchanged, mem[0..63] unchanged.
- After DONE: raise Start → ack falls next cycle. Change seed, lower Start → second run produces the new expected bytes.
- Preload memory while reset is high → contents survive reset release.
